// File: rtl/ascii_pkg.sv
// Shared definitions for the ASCII write buffer.
//   state_t              : FSM state encoding (CLEAR exists only when
//                          ASCII_WRITE_BUFFER_CLEAR_EN is defined)
//   BLANK_CHAR           : character written by a screen clear
//   DEFAULT_SCREEN_CELLS : cells swept by a clear (80x60 text screen)
package ascii_pkg;

`ifdef ASCII_WRITE_BUFFER_CLEAR_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1
  } state_t;
`endif

  localparam logic [7:0] BLANK_CHAR           = 8'h20;
  localparam int         DEFAULT_SCREEN_CELLS = 4800;

endpackage

// File: rtl/ascii_fifo.sv
// Synchronous FIFO holding pending character-RAM writes.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   push       : store push_data at the tail (ignored when full)
//   pop        : discard the head entry (ignored when empty)
//   push_data  : entry to store
//   head_data  : entry at the head (valid when empty=0)
//   full/empty : occupancy flags derived from the registered count
//   count      : number of stored entries, 0..DEPTH
// DEPTH must be a power of two (2..64) so the pointers wrap naturally.
module ascii_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 21
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       push_data,
  output logic [WIDTH-1:0]       head_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int            PW      = $clog2(DEPTH);
  localparam logic [PW:0]   DEPTH_C = (PW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok   = push && !full;
  assign pop_ok    = pop && !empty;
  assign full      = (count == DEPTH_C);
  assign empty     = (count == '0);
  assign head_data = mem[head];

  // Storage carries no reset; only entries between head and tail are ever read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[tail] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_ok) begin
        tail <= tail + 1'b1;
      end
      if (pop_ok) begin
        head <= head + 1'b1;
      end
      if (push_ok && !pop_ok) begin
        count <= count + 1'b1;
      end else if (pop_ok && !push_ok) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/ascii_write_buffer.sv
// Buffers core store-to-VGA writes and replays them into the character RAM,
// optionally sweeping the whole screen with blanks on request.
// Optional feature macro: ASCII_WRITE_BUFFER_CLEAR_EN (screen clear support).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   wr_en               : one store per asserted cycle (dropped while full)
//   wr_address          : target character cell
//   wr_data             : store data, bits [7:0] are the character
//   clear_req           : single-cycle request to blank the screen
//   char_ready          : character RAM accepts a write this cycle
//   char_write_en       : registered write strobe to the character RAM
//   char_write_address  : registered write address
//   char_write_data     : registered write character
//   full                : FIFO full
//   busy                : work pending (FSM active, FIFO non-empty or clear pending)
//   overflow            : sticky flag, a store was dropped; cleared only by rst
module ascii_write_buffer
  import ascii_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int ADDR_WIDTH   = 13,
  parameter int SCREEN_CELLS = DEFAULT_SCREEN_CELLS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_address,
  input  logic [31:0]           wr_data,
  input  logic                  clear_req,
  input  logic                  char_ready,
  output logic                  char_write_en,
  output logic [ADDR_WIDTH-1:0] char_write_address,
  output logic [7:0]            char_write_data,
  output logic                  full,
  output logic                  busy,
  output logic                  overflow
);

  localparam int                    CW        = $clog2(DEPTH) + 1;
  localparam int                    EW        = ADDR_WIDTH + 8;
  localparam logic [CW-1:0]         ONE_ENTRY = CW'(1);
  localparam logic [ADDR_WIDTH-1:0] LAST_CELL = ADDR_WIDTH'(SCREEN_CELLS - 1);

  state_t                state;
  logic                  push;
  logic                  pop;
  logic                  last_pop;
  logic                  fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic [EW-1:0]         head_entry;
  logic [ADDR_WIDTH-1:0] head_address;
  logic [7:0]            head_char;
  logic                  unused_inputs;

`ifdef ASCII_WRITE_BUFFER_CLEAR_EN
  logic                  clear_pending;
  logic [ADDR_WIDTH-1:0] sweep_addr;
`endif

  // Upper store bits and, in the default build, clear_req carry no function.
  assign unused_inputs = ^{wr_data[31:8], clear_req, LAST_CELL};

  // Acceptance looks only at the registered full flag, so a push arriving
  // while full is dropped even if the same cycle pops an entry.
  assign push = wr_en && !full;

  // IDLE issues the first write itself so a store reaches the RAM one edge
  // after it lands in the FIFO; entries are never bypassed around the FIFO.
  assign pop      = char_ready && !fifo_empty && (state == IDLE || state == DRAIN);
  assign last_pop = pop && !push && (fifo_count == ONE_ENTRY);

  assign {head_address, head_char} = head_entry;

  ascii_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data ({wr_address, wr_data[7:0]}),
    .head_data (head_entry),
    .full      (full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      char_write_en      <= 1'b0;
      char_write_address <= '0;
      char_write_data    <= '0;
      overflow           <= 1'b0;
`ifdef ASCII_WRITE_BUFFER_CLEAR_EN
      clear_pending      <= 1'b0;
      sweep_addr         <= '0;
`endif
    end else begin
      char_write_en <= 1'b0;
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
`ifdef ASCII_WRITE_BUFFER_CLEAR_EN
      if (clear_req) begin
        clear_pending <= 1'b1;
      end
`endif
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            if (pop) begin
              char_write_en      <= 1'b1;
              char_write_address <= head_address;
              char_write_data    <= head_char;
            end
            state <= last_pop ? IDLE : DRAIN;
          end
`ifdef ASCII_WRITE_BUFFER_CLEAR_EN
          else if (clear_pending) begin
            // Stores queued before the request are already out by now.
            sweep_addr <= '0;
            state      <= CLEAR;
          end
`endif
        end
        DRAIN: begin
          if (pop) begin
            char_write_en      <= 1'b1;
            char_write_address <= head_address;
            char_write_data    <= head_char;
          end
          if (fifo_empty || last_pop) begin
            state <= IDLE;
          end
        end
`ifdef ASCII_WRITE_BUFFER_CLEAR_EN
        CLEAR: begin
          // A fresh request restarts the sweep instead of queueing another.
          if (clear_req) begin
            sweep_addr <= '0;
          end else if (char_ready) begin
            char_write_en      <= 1'b1;
            char_write_address <= sweep_addr;
            char_write_data    <= BLANK_CHAR;
            if (sweep_addr == LAST_CELL) begin
              sweep_addr    <= '0;
              clear_pending <= 1'b0;
              state         <= IDLE;
            end else begin
              sweep_addr <= sweep_addr + 1'b1;
            end
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ASCII_WRITE_BUFFER_CLEAR_EN
  assign busy = (state != IDLE) || !fifo_empty || clear_pending;
`else
  assign busy = (state != IDLE) || !fifo_empty;
`endif

endmodule

// File: tb/tb_ascii_write_buffer.sv
// Self-checking bench for ascii_write_buffer (DEPTH=8, ADDR_WIDTH=13).
// Outside screen clears, a queue model predicts every write: on each edge the
// head leaves if char_ready is high, then a store joins if the queue held
// fewer than DEPTH entries before the edge. Clear sweeps are checked as a
// recorded write stream against the expected ordering.
module tb_ascii_write_buffer;

  localparam int DEPTH = 8;
  localparam int AW    = 13;
  localparam int CELLS = 4800;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_address = '0;
  logic [31:0]   wr_data = '0;
  logic          clear_req = 1'b0;
  logic          char_ready = 1'b0;
  logic          char_write_en;
  logic [AW-1:0] char_write_address;
  logic [7:0]    char_write_data;
  logic          full;
  logic          busy;
  logic          overflow;

  int tests = 0;
  int fails = 0;
  int writes = 0;
  bit clear_mode = 1'b0;

  logic [AW+7:0] model_q[$];
  logic [AW+7:0] obs_q[$];
  logic          exp_ovf = 1'b0;

  ascii_write_buffer #(
    .DEPTH        (DEPTH),
    .ADDR_WIDTH   (AW),
    .SCREEN_CELLS (CELLS)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .wr_en              (wr_en),
    .wr_address         (wr_address),
    .wr_data            (wr_data),
    .clear_req          (clear_req),
    .char_ready         (char_ready),
    .char_write_en      (char_write_en),
    .char_write_address (char_write_address),
    .char_write_data    (char_write_data),
    .full               (full),
    .busy               (busy),
    .overflow           (overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, advance one rising edge and check outputs #1 later.
  task automatic applyStimulus(input logic wr, input logic [AW-1:0] a,
                               input logic [7:0] d, input logic rdy,
                               input logic clr);
    logic [31:0]   r;
    logic          exp_en;
    logic [AW+7:0] exp_w;
    bit            accept;
    r          = $urandom;
    wr_en      = wr;
    wr_address = a;
    wr_data    = {r[31:8], d};
    char_ready = rdy;
    clear_req  = clr;
    exp_en     = 1'b0;
    exp_w      = '0;
    if (!clear_mode) begin
      if (rst) begin
        model_q.delete();
        exp_ovf = 1'b0;
      end else begin
        accept = wr && (model_q.size() < DEPTH);
        if (wr && !accept) exp_ovf = 1'b1;
        if (rdy && model_q.size() > 0) begin
          exp_en = 1'b1;
          exp_w  = model_q.pop_front();
        end
        if (accept) model_q.push_back({a, d});
      end
    end
    @(posedge clk);
    #1;
    if (char_write_en === 1'b1) writes++;
    if (clear_mode) begin
      if (char_write_en === 1'b1) begin
        obs_q.push_back({char_write_address, char_write_data});
        checkOutput("write_needs_ready", 32'(rdy), 32'd1);
      end
    end else begin
      checkOutput("char_write_en", 32'(char_write_en), 32'(exp_en));
      if (exp_en || rst) begin
        checkOutput("char_write_address", 32'(char_write_address), 32'(exp_w[AW+7:8]));
        checkOutput("char_write_data", 32'(char_write_data), 32'(exp_w[7:0]));
      end
      checkOutput("full", 32'(full), 32'(model_q.size() == DEPTH));
      checkOutput("busy", 32'(busy), 32'(model_q.size() != 0));
      checkOutput("overflow", 32'(overflow), 32'(exp_ovf));
    end
  endtask

  initial begin
    int            w0;
    int            bad;
    bit            pushed;
    bit            do_push;
    logic [AW+7:0] exp_w;

    // Reset state
    rst = 1'b1;
    applyStimulus(1'b0, '0, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    applyStimulus(1'b0, '0, 8'h00, 1'b1, 1'b0);

    // Single store reaches the RAM one edge after it is queued
    applyStimulus(1'b1, 13'h005, 8'h41, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 8'h00, 1'b1, 1'b0);

    // Nine pushes into an 8-deep FIFO with the RAM stalled
    for (int i = 0; i < 9; i++)
      applyStimulus(1'b1, AW'(16 + i), 8'(8'h61 + i), 1'b0, 1'b0);
    w0 = writes;
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b0, '0, 8'h00, 1'b1, 1'b0);
    checkOutput("overflow_drain_writes", 32'(writes - w0), 32'd8);

    // Three entries drained with char_ready toggling
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, AW'(200 + i), 8'(8'h30 + i), 1'b0, 1'b0);
    w0 = writes;
    for (int i = 0; i < 6; i++)
      applyStimulus(1'b0, '0, 8'h00, 1'(~i[0]), 1'b0);
    checkOutput("toggle_drain_writes", 32'(writes - w0), 32'd3);

    // Random traffic
    for (int i = 0; i < 300; i++)
      applyStimulus(1'($urandom_range(0, 1)), AW'($urandom), 8'($urandom),
                    1'($urandom_range(0, 9) < 6), 1'b0);
    for (int i = 0; i < 12; i++)
      applyStimulus(1'b0, '0, 8'h00, 1'b1, 1'b0);

    // Reset with four entries still queued mid-drain
    for (int i = 0; i < 6; i++)
      applyStimulus(1'b1, AW'(300 + i), 8'(8'h50 + i), 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 8'h00, 1'b1, 1'b0);
    rst = 1'b1;
    applyStimulus(1'b0, '0, 8'h00, 1'b1, 1'b0);
    rst = 1'b0;
    w0 = writes;
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b0, '0, 8'h00, 1'b1, 1'b0);
    checkOutput("writes_after_reset", 32'(writes - w0), 32'd0);

`ifdef ASCII_WRITE_BUFFER_CLEAR_EN
    // Two queued stores, then a clear: stores first, then the full sweep
    clear_mode = 1'b1;
    obs_q.delete();
    applyStimulus(1'b1, 13'h010, 8'h48, 1'b0, 1'b0);
    applyStimulus(1'b1, 13'h011, 8'h49, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 8000; i++) begin
      applyStimulus(1'b0, '0, 8'h00, 1'($urandom_range(0, 3) != 0), 1'b0);
      if (obs_q.size() >= CELLS + 2 && busy === 1'b0) break;
    end
    checkOutput("clear_write_count", 32'(obs_q.size()), 32'(CELLS + 2));
    if (obs_q.size() >= 2) begin
      checkOutput("clear_store0", 32'(obs_q[0]), 32'({13'h010, 8'h48}));
      checkOutput("clear_store1", 32'(obs_q[1]), 32'({13'h011, 8'h49}));
    end
    bad = 0;
    for (int i = 0; i < CELLS && i + 2 < obs_q.size(); i++) begin
      exp_w = {AW'(i), 8'h20};
      if (obs_q[i + 2] !== exp_w) bad++;
    end
    checkOutput("clear_sweep_errors", 32'(bad), 32'd0);
    checkOutput("clear_idle_busy", 32'(busy), 32'd0);

    // Store arriving mid-sweep waits until the last blank is written
    obs_q.delete();
    pushed = 1'b0;
    applyStimulus(1'b0, '0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 8000; i++) begin
      do_push = !pushed && obs_q.size() > 0 && obs_q[obs_q.size() - 1] === {13'd100, 8'h20};
      applyStimulus(do_push, 13'h123, 8'h5A, 1'($urandom_range(0, 3) != 0), 1'b0);
      if (do_push) pushed = 1'b1;
      if (obs_q.size() >= CELLS + 1 && busy === 1'b0) break;
    end
    checkOutput("mid_clear_pushed", 32'(pushed), 32'd1);
    checkOutput("mid_clear_write_count", 32'(obs_q.size()), 32'(CELLS + 1));
    bad = 0;
    for (int i = 0; i < CELLS && i < obs_q.size(); i++) begin
      exp_w = {AW'(i), 8'h20};
      if (obs_q[i] !== exp_w) bad++;
    end
    checkOutput("mid_clear_sweep_errors", 32'(bad), 32'd0);
    if (obs_q.size() > CELLS)
      checkOutput("mid_clear_store", 32'(obs_q[CELLS]), 32'({13'h123, 8'h5A}));
    checkOutput("mid_clear_idle_busy", 32'(busy), 32'd0);
    clear_mode = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ascii_write_buffer.md
ASCII_WRITE_BUFFER -- requirements
Module: ascii_write_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries, power of two, 2..64.
REQ-002 SHALL have parameter ADDR_WIDTH, default 13, character-cell address width.
REQ-003 SHALL have parameter SCREEN_CELLS, default 4800, number of cells swept by a clear (80x60).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port wr_en  input  1  core store-to-VGA strobe, one entry per asserted cycle.
REQ-007 SHALL have port wr_address  input  ADDR_WIDTH  target cell of the store.
REQ-008 SHALL have port wr_data  input  32  store data; bits [7:0] are the character.
REQ-009 SHALL have port clear_req  input  1  single-cycle request to blank the screen.
REQ-010 SHALL have port char_ready  input  1  character RAM accepts a write this cycle.
REQ-011 SHALL have port char_write_en  output  1  write strobe to character RAM.
REQ-012 SHALL have port char_write_address  output  ADDR_WIDTH  write address.
REQ-013 SHALL have port char_write_data  output  8  character written.
REQ-014 SHALL have ports full, busy and overflow, each output 1: FIFO full; work pending; sticky dropped-store flag.

Function
REQ-015 SHALL accept wr_en when full=0 and store {wr_address, wr_data[7:0]} at tail.
REQ-016 SHALL drop wr_en when full=0 is false, and set overflow; overflow SHALL clear only on rst.
REQ-017 SHALL decide acceptance from full as registered at the start of the cycle. A push in the same cycle as a pop while full SHALL be dropped.
REQ-018 SHALL have registered outputs. An entry pushed in cycle N SHALL drive char_write_en no earlier than cycle N+1. An empty FIFO SHALL NOT bypass entries.
REQ-019 SHALL have FSM states IDLE, DRAIN and CLEAR.
REQ-020 IDLE SHALL go to DRAIN when the FIFO is non-empty, and to CLEAR when a clear is pending and the FIFO is empty.
REQ-021 DRAIN SHALL drive the head entry with char_write_en=1 in each cycle char_ready=1, and pop it in the same cycle. When char_ready=0, DRAIN SHALL hold char_write_en=0 and hold the head entry.
REQ-022 DRAIN SHALL return to IDLE when the last entry pops.
REQ-023 SHALL latch clear_req into a pending flag in any state. A pending clear SHALL start only when the FIFO is empty, so earlier stores precede the clear.
REQ-024 CLEAR SHALL write 8'h20 to addresses 0..SCREEN_CELLS-1 in ascending order, advancing one address per char_ready=1 cycle. After the write to SCREEN_CELLS-1, CLEAR SHALL clear the pending flag and go to IDLE.
REQ-025 CLEAR SHALL keep accepting pushes into the FIFO; these drain after CLEAR ends.
REQ-026 SHALL restart the sweep from address 0 when clear_req is asserted during CLEAR, and SHALL NOT queue a second clear.
REQ-027 SHALL wrap head/tail pointers modulo DEPTH. full SHALL assert when count==DEPTH.
REQ-028 busy SHALL be 1 whenever state!=IDLE, the FIFO is non-empty, or a clear is pending.

Reset
REQ-029 rst SHALL set state=IDLE, head=tail=count=0, clear-pending=0, sweep address=0, and overflow=0.
REQ-030 rst SHALL set char_write_en=0, char_write_address=0 and char_write_data=0. full=0 and busy=0 in the cycle after rst.
REQ-031 rst asserted mid-drain or mid-clear SHALL discard all queued entries and the sweep without a further write.

Configuration
REQ-032 SHALL compile REQ-009, REQ-023..REQ-026 and the CLEAR state only when macro ASCII_WRITE_BUFFER_CLEAR_EN is defined.
REQ-033 Without ASCII_WRITE_BUFFER_CLEAR_EN: clear_req SHALL be ignored, the FSM SHALL have only IDLE and DRAIN, and busy SHALL equal (state!=IDLE || count!=0).

Structure
REQ-034 SHALL take the state encoding enum, the 8'h20 blank constant and the default SCREEN_CELLS from shared package ascii_pkg.
REQ-035 SHALL put the FIFO storage and pointers in one sub-module, ascii_fifo (push/pop/full/empty/count); the FSM and sweep counter stay in ascii_write_buffer.

Verification
REQ-036 The bench SHALL check: push (0x005,'A') with char_ready=1 -> char_write_en=1, address 0x005, data 0x41 exactly one cycle later; busy=0 the cycle after.
REQ-037 The bench SHALL check: char_ready=0, 9 consecutive pushes at DEPTH=8 -> full=1 after the 8th, 9th dropped, overflow=1. Then char_ready=1 -> exactly 8 writes in push order.
REQ-038 The bench SHALL check: char_ready toggled 1,0,1,0 while draining 3 entries -> a write only in char_ready=1 cycles, with no entry lost or duplicated.
REQ-039 The bench SHALL check (ASCII_WRITE_BUFFER_CLEAR_EN): 2 queued stores then clear_req -> both stores written first, then 4800 writes of 0x20 at addresses 0..4799, then IDLE.
REQ-040 The bench SHALL check: push during CLEAR at sweep address 100 -> entry held until address 4799 is written, then drained.
REQ-041 The bench SHALL check: rst asserted with 4 entries queued mid-drain -> the next cycle has char_write_en=0, count=0, busy=0, and no later writes.
